iobm_mc: RTL



---
 rtl/iobm_mc_if.sv | 38 +++
 rtl/iobm_mc.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/iobm_mc_if.sv
// Requester-side and PDS-side signal bundle of the iobm_mc bus master.
// The master modport is the bus master; the slave modport is the requesters plus the PDS bus.
interface iobm_mc_if #(
  parameter int NCH = 2
);
  logic           C8M;
  logic           E;
  logic           nDTACK;
  logic           nVPA;
  logic           nBERR;
  logic           AoutOE;
  logic [NCH-1:0] REQ;
  logic [NCH-1:0] RW;
  logic [NCH-1:0] LDS;
  logic [NCH-1:0] UDS;
  logic [NCH-1:0] DONE;
  logic [NCH-1:0] ERR;
  logic [NCH-1:0] GNT;
  logic           IOACT;
  logic           nAS;
  logic           RnW;
  logic           nLDS;
  logic           nUDS;
  logic           nVMA;
  logic           ALE0;
  logic           nDinLE;
  logic           nDoutOE;

  modport master (
    input  C8M, E, nDTACK, nVPA, nBERR, AoutOE, REQ, RW, LDS, UDS,
    output DONE, ERR, GNT, IOACT, nAS, RnW, nLDS, nUDS, nVMA, ALE0, nDinLE, nDoutOE
  );

  modport slave (
    output C8M, E, nDTACK, nVPA, nBERR, AoutOE, REQ, RW, LDS, UDS,
    input  DONE, ERR, GNT, IOACT, nAS, RnW, nLDS, nUDS, nVMA, ALE0, nDinLE, nDoutOE
  );
endinterface

// File: rtl/iobm_mc.sv
// Multi-channel round-robin PDS (68000-style) bus master with DTACK, VPA/E and BERR termination.
// Define IOBM_TIMEOUT_EN to add the WAIT-state timeout that ends a stuck cycle as a bus error.
module iobm_mc #(
  parameter int NCH    = 2,
  parameter int ES_LEN = 10,
  parameter int VMA_ES = 4
`ifdef IOBM_TIMEOUT_EN
  , parameter int TOUT = 255
`endif
) (
  input logic       C16M,
  input logic       nRES,
  iobm_mc_if.master bus
);
  localparam int PW  = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int ESW = $clog2(ES_LEN);

  typedef enum logic [2:0] {IDLE, S2, S3, S4, WAIT, S6, S7} state_t;

  state_t         state;
  logic [PW-1:0]  ptr;
  logic [PW-1:0]  g_idx;
  logic [NCH-1:0] gnt, done, err;
  logic           ioact, as_n, rnw, lds_n, uds_n, vma_n, ale0, din_le_n, dout_oe_n;
  logic           term, term_err;

  logic           c8m_r, c8m_d, e_r, e_d;
  logic           dtack_r, vpa_r, berr_r;
  logic           e_pend;
  logic [ESW-1:0] es;
  logic           c8m_fall, c8m_rise, e_fall, etack;

  logic           any_sel;
  logic [PW-1:0]  sel;

`ifdef IOBM_TIMEOUT_EN
  logic [7:0]     tcnt;
`endif

  assign c8m_fall = c8m_d & ~c8m_r;
  assign c8m_rise = ~c8m_d & c8m_r;
  assign e_fall   = e_d & ~e_r;
  assign etack    = (int'(es) == VMA_ES + 4) && !vma_n;

  // Bus-clock sampling, E-clock phase counter (ES) and VMA generation.
  // NOTE: sequential state uses non-blocking assignments only, so every flop sees pre-edge values.
  always_ff @(posedge C16M or negedge nRES) begin
    if (!nRES) begin
      c8m_r   <= 1'b0;
      c8m_d   <= 1'b0;
      e_r     <= 1'b0;
      e_d     <= 1'b0;
      dtack_r <= 1'b1;
      vpa_r   <= 1'b1;
      berr_r  <= 1'b1;
      e_pend  <= 1'b0;
      es      <= '0;
      vma_n   <= 1'b1;
    end else begin
      c8m_r   <= bus.C8M;
      c8m_d   <= c8m_r;
      e_r     <= bus.E;
      e_d     <= e_r;
      dtack_r <= bus.nDTACK;
      vpa_r   <= bus.nVPA;
      berr_r  <= bus.nBERR;

      // ES only runs after an E falling edge; once it wraps it parks at 0.
      if (c8m_fall) begin
        e_pend <= e_fall;
        if (e_pend)                                es <= ESW'(1);
        else if (es == '0 || int'(es) == ES_LEN-1) es <= '0;
        else                                       es <= es + 1'b1;
      end else if (e_fall) begin
        e_pend <= 1'b1;
      end

      if (es == '0)
        vma_n <= 1'b1;
      else if (c8m_rise && int'(es) == VMA_ES && state == WAIT && !vpa_r)
        vma_n <= 1'b0;
    end
  end

  // Round-robin pick: first requester after the pointer.
  // NOTE: every always_comb output gets a default first, so no latch is inferred.
  always_comb begin
    any_sel = 1'b0;
    sel     = ptr;
    for (int i = 1; i <= NCH; i++) begin
      for (int c = 0; c < NCH; c++) begin
        if (!any_sel && c == (int'(ptr) + i) % NCH && bus.REQ[c]) begin
          any_sel = 1'b1;
          sel     = PW'(c);
        end
      end
    end
  end

  always_ff @(posedge C16M or negedge nRES) begin
    if (!nRES) begin
      state     <= IDLE;
      ptr       <= PW'(NCH-1);
      g_idx     <= '0;
      gnt       <= '0;
      done      <= '0;
      err       <= '0;
      ioact     <= 1'b0;
      as_n      <= 1'b1;
      rnw       <= 1'b1;
      lds_n     <= 1'b1;
      uds_n     <= 1'b1;
      ale0      <= 1'b0;
      din_le_n  <= 1'b0;
      dout_oe_n <= 1'b1;
      term      <= 1'b0;
      term_err  <= 1'b0;
`ifdef IOBM_TIMEOUT_EN
      tcnt      <= '0;
`endif
    end else begin
      done <= '0;
      err  <= '0;
`ifdef IOBM_TIMEOUT_EN
      tcnt <= (state == WAIT) ? tcnt + 8'd1 : 8'd0;
`endif
      case (state)
        IDLE: begin
          term     <= 1'b0;
          term_err <= 1'b0;
          if (any_sel && !c8m_r && bus.AoutOE) begin
            state     <= S2;
            g_idx     <= sel;
            ptr       <= sel;
            gnt       <= NCH'(1) << sel;
            ioact     <= 1'b1;
            ale0      <= 1'b1;
            as_n      <= 1'b0;
            rnw       <= bus.RW[sel];
            dout_oe_n <= bus.RW[sel];
            if (bus.RW[sel]) begin
              lds_n <= ~bus.LDS[sel];
              uds_n <= ~bus.UDS[sel];
            end
          end
        end
        S2: state <= S3;
        S3: begin
          state    <= S4;
          din_le_n <= 1'b1;
          // Write strobes wait until the data bus is driven.
          if (!rnw) begin
            lds_n <= ~bus.LDS[g_idx];
            uds_n <= ~bus.UDS[g_idx];
          end
        end
        S4: state <= WAIT;
        WAIT: begin
          if (c8m_fall && !term && (!dtack_r || etack || !berr_r)) begin
            term     <= 1'b1;
            term_err <= !berr_r;
          end
`ifdef IOBM_TIMEOUT_EN
          if (tcnt == 8'(TOUT) && !term) begin
            term     <= 1'b1;
            term_err <= 1'b1;
          end
`endif
          if (!c8m_r && term) begin
            state    <= S6;
            as_n     <= 1'b1;
            lds_n    <= 1'b1;
            uds_n    <= 1'b1;
            din_le_n <= 1'b0;
            done     <= gnt;
            err      <= term_err ? gnt : '0;
          end
        end
        S6: begin
          state     <= S7;
          ale0      <= 1'b0;
          ioact     <= 1'b0;
          rnw       <= 1'b1;
          dout_oe_n <= 1'b1;
        end
        S7: begin
          state <= IDLE;
          gnt   <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.GNT     = gnt;
  assign bus.DONE    = done;
  assign bus.ERR     = err;
  assign bus.IOACT   = ioact;
  assign bus.nAS     = as_n;
  assign bus.RnW     = rnw;
  assign bus.nLDS    = lds_n;
  assign bus.nUDS    = uds_n;
  assign bus.nVMA    = vma_n;
  assign bus.ALE0    = ale0;
  assign bus.nDinLE  = din_le_n;
  assign bus.nDoutOE = dout_oe_n;
endmodule
